// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - framed serial transmitter: start, LSB-first data, optional parity, stop
module serial_frame_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 out,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 last_cyc;
  logic                 accept;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    last_cyc = (cyc_q == CYC_LAST);
    in_ready = (state_q == S_IDLE) || ((state_q == S_STOP) && last_cyc);
    accept   = in_valid && in_ready && !areset;

    if (state_q != S_IDLE) begin
      cyc_d = last_cyc ? '0 : cyc_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cyc_d   = '0;
          shift_d = in_data;
          par_d   = (^in_data) ^ (PARITY_ODD != 0);
        end
      end
      S_START: begin
        if (last_cyc) state_d = S_DATA;
      end
      S_DATA: begin
        if (last_cyc) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (last_cyc) state_d = S_STOP;
      end
      S_STOP: begin
        if (last_cyc) begin
          if (accept) begin
            // back-to-back: reload and go straight to the next start bit
            state_d = S_START;
            cyc_d   = '0;
            shift_d = in_data;
            par_d   = (^in_data) ^ (PARITY_ODD != 0);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so the line changes on the accept edge
    case (state_d)
      S_START:  out_d = 1'b0;
      S_DATA:   out_d = shift_d[0];
      S_PARITY: out_d = par_d;
      default:  out_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cyc_d == CYC_LAST);
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - three configurations of serial_frame_tx against a frame-level model
module tb_serial_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       areset;
  logic       vld [3];
  logic [7:0] dat [3];
  logic       rdy [3];
  logic       so  [3];
  logic       bsy [3];
  logic       dn  [3];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // instance 0: defaults; 1: odd parity, 3 cycles/bit; 2: no parity
  function automatic int pe(int i);
    return (i == 2) ? 0 : 1;
  endfunction
  function automatic bit po(int i);
    return (i == 1);
  endfunction
  function automatic int bc(int i);
    return (i == 1) ? 3 : 1;
  endfunction
  function automatic int flen(int i);
    return (8 + pe(i) + 2) * bc(i);
  endfunction

  serial_frame_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .BIT_CYCLES(1)) dut_a (
    .clk(clk), .areset(areset), .in_valid(vld[0]), .in_data(dat[0]),
    .in_ready(rdy[0]), .out(so[0]), .busy(bsy[0]), .done(dn[0]));
  serial_frame_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .BIT_CYCLES(3)) dut_b (
    .clk(clk), .areset(areset), .in_valid(vld[1]), .in_data(dat[1]),
    .in_ready(rdy[1]), .out(so[1]), .busy(bsy[1]), .done(dn[1]));
  serial_frame_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .BIT_CYCLES(1)) dut_c (
    .clk(clk), .areset(areset), .in_valid(vld[2]), .in_data(dat[2]),
    .in_ready(rdy[2]), .out(so[2]), .busy(bsy[2]), .done(dn[2]));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model: the frame as a bit vector plus a cycle position inside it (-1 = idle)
  int         pos [3] = '{-1, -1, -1};
  logic [11:0] fr [3];

  function automatic bit m_ready(int i);
    return (pos[i] < 0) || (pos[i] == flen(i) - 1);
  endfunction
  function automatic bit m_out(int i);
    return (pos[i] < 0) ? 1'b1 : fr[i][pos[i] / bc(i)];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (areset) begin
        pos[i] = -1;
      end else if (vld[i] && m_ready(i)) begin
        fr[i]      = '0;
        fr[i][8:1] = dat[i];
        if (pe(i) != 0) fr[i][9] = (^dat[i]) ^ po(i);
        fr[i][9 + pe(i)] = 1'b1;
        pos[i] = 0;
      end else if (pos[i] >= 0) begin
        pos[i]++;
        if (pos[i] == flen(i)) pos[i] = -1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out%0d", i), so[i], m_out(i));
        chk($sformatf("busy%0d", i), bsy[i], pos[i] >= 0);
        chk($sformatf("done%0d", i), dn[i], pos[i] == flen(i) - 1);
        chk($sformatf("ready%0d", i), rdy[i], m_ready(i));
      end
    end
  end

  task automatic send_cap(input int i, input logic [7:0] d, input int n,
                          output logic [63:0] seq, output logic [63:0] dseq);
    seq  = '0;
    dseq = '0;
    vld[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    vld[i] = 1'b0;
    dat[i] = 8'($urandom);
    for (int j = 0; j < n; j++) begin
      seq[j]  = so[i];
      dseq[j] = dn[i];
      @(negedge clk);
    end
  endtask

  logic [63:0] s, ds;
  int bcnt, dcnt, rcnt, sec_at;
  bit prev_rdy [3];
  bit prev_rst;

  initial begin
    areset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      dat[i] = '0;
    end
    repeat (2) @(negedge clk);
    areset = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_out", so[0], 1'b1);
    chk("idle_busy", bsy[0], 1'b0);
    chk("idle_done", dn[0], 1'b0);
    chk("idle_ready", rdy[0], 1'b1);

    send_cap(0, 8'hA5, 11, s, ds);
    chk("a5_line", s[10:0], 11'h54A);
    chk("a5_done", ds[10:0], 11'h400);
    chk("a5_after", so[0], 1'b1);

    send_cap(1, 8'h01, 33, s, ds);
    chk("odd_line", s[32:0], 33'h1C0000038);
    chk("odd_done", ds[32:0], 33'h100000000);

    send_cap(2, 8'hFF, 10, s, ds);
    chk("nopar_line", s[9:0], 10'h3FE);
    chk("nopar_done", ds[9:0], 10'h200);

    // back-to-back with in_valid held high
    vld[0] = 1'b1;
    dat[0] = 8'h0F;
    @(negedge clk);
    dat[0] = 8'hF0;
    bcnt = 0; dcnt = 0; rcnt = 0; sec_at = -1; s = '0;
    for (int j = 0; j < 22; j++) begin
      bcnt += int'(bsy[0]);
      dcnt += int'(dn[0]);
      rcnt += int'(rdy[0]);
      s[j] = so[0];
      if (rdy[0] && vld[0]) sec_at = j;
      @(negedge clk);
      if (j == sec_at) vld[0] = 1'b0;
    end
    chk("b2b_line", s[21:0], 22'h2F041E);
    chk("b2b_busy_cycles", 64'(bcnt), 64'd22);
    chk("b2b_done_pulses", 64'(dcnt), 64'd2);
    chk("b2b_ready_cycles", 64'(rcnt), 64'd2);
    chk("b2b_second_accept", 64'(sec_at), 64'd10);
    chk("b2b_idle_after", bsy[0], 1'b0);

    // reset during data bit 4
    vld[0] = 1'b1;
    dat[0] = 8'h00;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_bit4", so[0], 1'b0);
    chk("mid_busy", bsy[0], 1'b1);
    areset = 1'b1;
    vld[0] = 1'b1;
    dat[0] = 8'h55;
    @(negedge clk);
    areset = 1'b0;
    vld[0] = 1'b0;
    chk("rst_out", so[0], 1'b1);
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_done", dn[0], 1'b0);
    send_cap(0, 8'h3C, 11, s, ds);
    chk("3c_line", s[10:0], 11'h478);
    chk("3c_done", ds[10:0], 11'h400);

    // randomized traffic on all three instances; a pending word is held until taken
    for (int i = 0; i < 3; i++) prev_rdy[i] = 1'b0;
    prev_rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(vld[i] && !(prev_rdy[i] && !prev_rst))) begin
          vld[i] = ($urandom % 3) != 0;
          dat[i] = 8'($urandom);
        end
        prev_rdy[i] = rdy[i];
      end
      areset   = ($urandom % 250) == 0;
      prev_rst = areset;
      @(negedge clk);
    end
    areset = 1'b0;
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    repeat (40) @(negedge clk);
    chk("final_idle_a", bsy[0], 1'b0);
    chk("final_idle_b", bsy[1], 1'b0);
    chk("final_idle_c", bsy[2], 1'b0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
Serializer that drives a single-bit serial line with framed bytes. Each frame is a start bit (0), DATA_BITS data bits sent LSB first, an optional parity bit, and a stop bit (1). It is the transmitting end of the serial-frame protocol consumed by the team's bit-stream FSM receivers. It takes parallel words through a valid/ready handshake and holds the line idle-high between frames.

Parameters:
DATA_BITS, 8, number of data bits per frame (1..16)
PARITY_EN, 1, 1 = insert parity bit after data; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity; 1 = odd parity (ignored when PARITY_EN=0)
BIT_CYCLES, 1, clock cycles each serial bit is held on out (1..255)

Ports:
clk  input  1  system clock, all state changes on rising edge
areset  input  1  synchronous active-high reset, sampled only on rising clk
in_valid  input  1  upstream word available
in_data  input  DATA_BITS  word to transmit
in_ready  output  1  block can accept a word this cycle
out  output  1  serial line, registered, idle high
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse during the final cycle of the stop bit

Behaviour:
- Reset (areset=1 at a rising edge): state=IDLE, out=1, busy=0, done=0, bit and cycle counters=0. Any frame in flight is abandoned; the line returns high on the next cycle.
- areset has priority over every other input. A word presented while areset=1 is not accepted.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE or START.
- Each non-IDLE state lasts exactly BIT_CYCLES cycles, timed by a cycle counter that counts 0..BIT_CYCLES-1.
- in_ready = 1 in IDLE, and in the final cycle of STOP. It is 0 at all other times.
- Accept: a word is taken when in_valid && in_ready at a rising edge. in_data is latched into a shift register, and parity is computed from the latched word.
- Parity bit = XOR of the data bits, XORed with PARITY_ODD.
- Latency: on acceptance at edge k, out=0 (start bit) from edge k onward for BIT_CYCLES cycles.
- DATA: bit i is driven for BIT_CYCLES cycles, i = 0..DATA_BITS-1, LSB first. The shift register shifts right at each bit boundary. The bit counter wraps to 0 on leaving DATA.
- PARITY: out = parity bit. STOP: out = 1.
- Frame length is (DATA_BITS + PARITY_EN + 2) * BIT_CYCLES cycles.
- done=1 exactly during the last cycle of STOP, and is 0 otherwise.
- Back-to-back: if a word is accepted in the last STOP cycle, the next state is START with no idle gap, and busy stays 1.
- Without an accept in the last STOP cycle, the next state is IDLE and busy=0.
- in_valid deasserted mid-frame has no effect.
- Changes on in_data after acceptance do not affect the frame in flight.
- in_valid held high while in_ready=0: the word is not consumed. Upstream holds it until in_ready=1.
- out, busy and done are registered. No combinational path from inputs to out.

Test Plan:
- Reset then idle, areset=1 for 2 cycles, then in_valid=0 for 20 cycles -> out=1, busy=0, done=0, in_ready=1 throughout.
- Even-parity byte, defaults, send 0xA5 -> out = 0,1,0,1,0,0,1,0,1,0,1 over 11 consecutive cycles. The sequence is start, LSB-first data, parity 0, stop. done pulses on cycle 11, then the line stays 1.
- Odd parity with stretched bits, PARITY_ODD=1, BIT_CYCLES=3, send 0x01 -> start 0 (3 cycles), then 1 (3 cycles), then 0 for 21 cycles. Parity 0 (3 cycles), stop 1 (3 cycles). Total 33 cycles.
- Back-to-back, in_valid held high with 0x0F then 0xF0 -> second start bit directly follows the first stop bit with no idle cycle. in_ready high only on the final STOP cycle. done pulses once per frame.
- No parity, PARITY_EN=0, send 0xFF -> out = 0, eight 1s, stop 1: a 10-cycle frame.
- Reset mid-frame: assert areset during data bit 4 of 0x00 -> out=1 and busy=0 on the next cycle, no done pulse. A following send of 0x3C yields a complete, correct frame.
